// File: rtl/pps_if.sv
// pps_if: signal bundle between a PPS generator and the logic that drives and consumes it.
//
// There is no valid/ready backpressure on this bundle, and none is needed.
//   - `align` is a single-cycle request that the generator always accepts.
//   - `pps_stb` acts as the "valid" for `pps_seq` and `timer_cnt_out`:
//     both are fresh while it is high and simply hold afterwards.
//
// Modports:
//   master : drives en, align, period, width, timer_cnt_in; observes the outputs.
//   slave  : the generator itself.
//
// `dbg_state` exposes the generator FSM: 0 = IDLE, 1 = RUN.
interface pps_if #(
  parameter int TIMER_W = 94,
  parameter int CNT_W   = 32
);
  logic               en;
  logic               align;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   width;
  logic [TIMER_W-1:0] timer_cnt_in;
  logic               pps;
  logic               pps_stb;
  logic [CNT_W-1:0]   pps_seq;
  logic [TIMER_W-1:0] timer_cnt_out;
  logic               dbg_state;

  modport master (
    output en, align, period, width, timer_cnt_in,
    input  pps, pps_stb, pps_seq, timer_cnt_out, dbg_state
  );

  modport slave (
    input  en, align, period, width, timer_cnt_in,
    output pps, pps_stb, pps_seq, timer_cnt_out, dbg_state
  );
endinterface

// File: rtl/pps_gen.sv
// pps_gen: programmable pulse-per-second generator, the transmit end of the PPS timestamp path.
//
// Emits a registered periodic `pps` pulse with a programmable period and high width.
// On every pulse start it latches the timer value and a sequence number, so a
// loop-back capture path can compare what it saw against what was sent.
//
// Ports:
//   clk  : system clock; all logic runs on the rising edge.
//   rst  : synchronous, active-high reset.
//   bus  : pps_if.slave, which carries:
//            inputs  en, align, period, width, timer_cnt_in
//            outputs pps, pps_stb, pps_seq, timer_cnt_out, dbg_state
module pps_gen #(
  parameter int TIMER_W = 94,
  parameter int CNT_W   = 32
) (
  input  logic clk,
  input  logic rst,
  pps_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   per_q, per_d;   // shadow period, changes only at a pulse start
  logic [CNT_W-1:0]   wid_q, wid_d;   // shadow width, changes only at a pulse start
  logic [CNT_W-1:0]   seq_q, seq_d;
  logic [TIMER_W-1:0] ts_q, ts_d;
  logic               pps_q, pps_d;
  logic               stb_q, stb_d;

  logic [CNT_W-1:0]   eff_p;
  logic [CNT_W-1:0]   eff_w;
  logic [CNT_W-1:0]   phase_inc;
  logic               pulse_start;

  // Clamp the programmed values.
  // These are only consumed when the shadows load, so the clamp sees the inputs
  // exactly at the period boundary. A period below 2 or a width at/above the
  // period would leave no low cycle, which the downstream edge detector needs.
  always_comb begin
    eff_p = (bus.period < P_MIN) ? P_MIN : bus.period;
    if (bus.width == '0) begin
      eff_w = ONE;
    end else if (bus.width >= eff_p) begin
      eff_w = eff_p - ONE;
    end else begin
      eff_w = bus.width;
    end
  end

  assign phase_inc = phase_q + ONE;

  // Three sources of a pulse start: leaving IDLE, an align strobe, or a natural wrap.
  // An align that coincides with a wrap is still a single start.
  // The en term makes a falling en win over align.
  assign pulse_start = bus.en &&
                       ((state_q == ST_IDLE) || bus.align || (phase_q == per_q - ONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: en is a plain level run enable.
  always_comb begin
    state_d = bus.en ? ST_RUN : ST_IDLE;
  end

  // Output / datapath next values
  always_comb begin
    phase_d = phase_q;
    per_d   = per_q;
    wid_d   = wid_q;
    seq_d   = seq_q;
    ts_d    = ts_q;
    pps_d   = 1'b0;
    stb_d   = 1'b0;
    if (!bus.en) begin
      // Disabled: truncate any pulse in progress, but keep seq and timestamp.
      phase_d = '0;
    end else if (pulse_start) begin
      phase_d = '0;
      per_d   = eff_p;
      wid_d   = eff_w;
      pps_d   = 1'b1;  // eff_w >= 1, so phase 0 is always high
      stb_d   = 1'b1;
      ts_d    = bus.timer_cnt_in;
      seq_d   = (state_q == ST_IDLE) ? '0 : seq_q + ONE;
    end else begin
      phase_d = phase_inc;
      pps_d   = (phase_inc < wid_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      per_q   <= P_MIN;
      wid_q   <= ONE;
      seq_q   <= '0;
      ts_q    <= '0;
      pps_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      per_q   <= per_d;
      wid_q   <= wid_d;
      seq_q   <= seq_d;
      ts_q    <= ts_d;
      pps_q   <= pps_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.pps           = pps_q;
  assign bus.pps_stb       = stb_q;
  assign bus.pps_seq       = seq_q;
  assign bus.timer_cnt_out = ts_q;
  assign bus.dbg_state     = (state_q == ST_RUN);

endmodule

// File: tb/tb_pps_gen.sv
module tb_pps_gen;

  localparam int TW = 94;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;

  pps_if #(.TIMER_W(TW), .CNT_W(CW)) bus ();

  pps_gen #(.TIMER_W(TW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] ts_before;
  logic [TW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Tracks the pulse train as "age since last pulse start"
  // against the clamped period/width captured at that start.
  bit            m_run;
  longint        m_age, m_p, m_w;
  logic          m_pps, m_stb;
  logic [CW-1:0] m_seq;
  logic [TW-1:0] m_ts;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_age = 0; m_p = 2; m_w = 1;
      m_pps = 0; m_stb = 0; m_seq = '0; m_ts = '0;
    end else if (!bus.en) begin
      m_run = 0; m_pps = 0; m_stb = 0;
    end else begin
      if (!m_run || bus.align || (m_age + 1 == m_p)) begin
        m_seq = m_run ? m_seq + 1 : '0;
        m_run = 1;
        m_age = 0;
        m_p = (longint'(bus.period) < 2) ? 2 : longint'(bus.period);
        if (bus.width == '0)                  m_w = 1;
        else if (longint'(bus.width) >= m_p)  m_w = m_p - 1;
        else                                  m_w = longint'(bus.width);
        m_ts  = bus.timer_cnt_in;
        m_stb = 1;
      end else begin
        m_age = m_age + 1;
        m_stb = 0;
      end
      m_pps = (m_age < m_w);
    end
  end

  // ---------------- driver ----------------
  // One clock edge; the timer value is refreshed away from the edge.
  task automatic tick();
    ts_before = bus.timer_cnt_in;
    @(posedge clk);
    #1;
    bus.timer_cnt_in = TW'({$urandom, $urandom, $urandom});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; bus.en = 1; bus.align = 1;
    bus.period = 32'd7; bus.width = 32'd3;
    repeat (3) tick();
    checks++;
    if (bus.pps !== 1'b0 || bus.pps_stb !== 1'b0 || bus.pps_seq !== '0 ||
        bus.timer_cnt_out !== '0 || bus.dbg_state !== 1'b0)
      begin errors++; $display("FAIL reset_state pps=%b stb=%b seq=%h ts=%h st=%b required all zero",
        bus.pps, bus.pps_stb, bus.pps_seq, bus.timer_cnt_out, bus.dbg_state); end
    rst = 0; bus.en = 0; bus.align = 0;
    tick();
    checks++;
    if (bus.pps !== 1'b0 || bus.dbg_state !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset pps=%b st=%b required 0 0", bus.pps, bus.dbg_state); end
  endtask

  task automatic test_enable();
    bus.period = 32'd10; bus.width = 32'd3;
    repeat (3) tick();
    bus.en = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.pps !== ((i % 10) < 3) || bus.pps_stb !== ((i % 10) == 0) ||
          bus.pps_seq !== CW'(i / 10))
        begin errors++; $display("FAIL enable_wave i=%0d pps=%b stb=%b seq=%0d required %b %b %0d",
          i, bus.pps, bus.pps_stb, bus.pps_seq, (i % 10) < 3, (i % 10) == 0, i / 10); end
      if ((i % 10) == 0) begin
        exp_q.push_back(ts_before);
        checks++;
        if (bus.timer_cnt_out !== exp_q[0])
          begin errors++; $display("FAIL enable_ts i=%0d got %h required %h", i, bus.timer_cnt_out, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_reprogram();
    int n;
    bit got;
    tick();  // wrap -> phase 0
    checks++;
    if (bus.pps_stb !== 1'b1) begin errors++; $display("FAIL reprog_start stb=%b required 1", bus.pps_stb); end
    repeat (4) tick();  // phase 4
    bus.period = 32'd6; bus.width = 32'd2;
    n = 0; got = 0;
    while (!got && n < 20) begin
      tick(); n++;
      if (bus.pps_stb === 1'b1) got = 1;
    end
    checks++;
    if (!got || n != 6) begin errors++; $display("FAIL reprog_finish cycles=%0d required 6", n); end
    for (int i = 1; i < 13; i++) begin
      tick();
      checks++;
      if (bus.pps !== ((i % 6) < 2) || bus.pps_stb !== ((i % 6) == 0) || bus.pps !== m_pps)
        begin errors++; $display("FAIL reprog_wave i=%0d pps=%b stb=%b required %b %b",
          i, bus.pps, bus.pps_stb, (i % 6) < 2, (i % 6) == 0); end
    end
  endtask

  task automatic test_clamp();
    int n;
    bit got;
    bus.period = 32'd1; bus.width = 32'd0;
    n = 0; got = 0;
    while (!got && n < 20) begin tick(); n++; if (bus.pps_stb === 1'b1) got = 1; end
    checks++;
    if (!got) begin errors++; $display("FAIL clamp_a_timeout stb never seen"); end
    for (int i = 1; i < 9; i++) begin
      tick();
      checks++;
      if (bus.pps !== ((i % 2) == 0) || bus.pps_stb !== ((i % 2) == 0))
        begin errors++; $display("FAIL clamp_a i=%0d pps=%b stb=%b required %b", i, bus.pps, bus.pps_stb, (i % 2) == 0); end
    end
    bus.period = 32'd5; bus.width = 32'd9;
    n = 0; got = 0;
    while (!got && n < 20) begin tick(); n++; if (bus.pps_stb === 1'b1) got = 1; end
    checks++;
    if (!got) begin errors++; $display("FAIL clamp_b_timeout stb never seen"); end
    for (int i = 1; i < 11; i++) begin
      tick();
      checks++;
      if (bus.pps !== ((i % 5) < 4) || bus.pps_stb !== ((i % 5) == 0))
        begin errors++; $display("FAIL clamp_b i=%0d pps=%b stb=%b required %b %b",
          i, bus.pps, bus.pps_stb, (i % 5) < 4, (i % 5) == 0); end
    end
  endtask

  task automatic test_align();
    int n;
    bit got;
    logic [CW-1:0] base;
    bus.period = 32'd10; bus.width = 32'd3;
    n = 0; got = 0;
    while (!got && n < 20) begin tick(); n++; if (bus.pps_stb === 1'b1) got = 1; end
    checks++;
    if (!got) begin errors++; $display("FAIL align_sync_timeout stb never seen"); end
    base = m_seq;
    repeat (6) tick();  // phase 6
    checks++;
    if (bus.pps !== 1'b0) begin errors++; $display("FAIL align_pre pps=%b required 0", bus.pps); end
    bus.align = 1;
    tick();
    bus.align = 0;
    checks++;
    if (bus.pps !== 1'b1 || bus.pps_stb !== 1'b1 || bus.pps_seq !== base + 1 || bus.timer_cnt_out !== ts_before)
      begin errors++; $display("FAIL align_mid pps=%b stb=%b seq=%h required 1 1 %h",
        bus.pps, bus.pps_stb, bus.pps_seq, base + 1); end
    for (int i = 1; i < 11; i++) begin
      tick();
      checks++;
      if (bus.pps !== ((i % 10) < 3) || bus.pps_stb !== (i == 10))
        begin errors++; $display("FAIL align_after i=%0d pps=%b stb=%b required %b %b",
          i, bus.pps, bus.pps_stb, (i % 10) < 3, i == 10); end
    end
    checks++;
    if (bus.pps_seq !== base + 2) begin errors++; $display("FAIL align_seq2 got %h required %h", bus.pps_seq, base + 2); end
    repeat (9) tick();  // phase 9: the next edge is a natural wrap
    bus.align = 1;
    tick();
    bus.align = 0;
    checks++;
    if (bus.pps_stb !== 1'b1 || bus.pps_seq !== base + 3)
      begin errors++; $display("FAIL align_on_wrap stb=%b seq=%h required 1 %h", bus.pps_stb, bus.pps_seq, base + 3); end
    tick();  // phase 1, still high
    checks++;
    if (bus.pps !== 1'b1 || bus.pps_stb !== 1'b0 || bus.pps_seq !== base + 3)
      begin errors++; $display("FAIL align_wrap_once pps=%b stb=%b seq=%h required 1 0 %h",
        bus.pps, bus.pps_stb, bus.pps_seq, base + 3); end
  endtask

  task automatic test_disable();
    logic [CW-1:0] seq_h;
    logic [TW-1:0] ts_h;
    seq_h = m_seq; ts_h = m_ts;  // phase 1 of a running pulse
    bus.en = 0;
    tick();
    checks++;
    if (bus.pps !== 1'b0 || bus.pps_stb !== 1'b0 || bus.pps_seq !== seq_h ||
        bus.timer_cnt_out !== ts_h || bus.dbg_state !== 1'b0)
      begin errors++; $display("FAIL disable pps=%b stb=%b seq=%h ts=%h required 0 0 %h %h",
        bus.pps, bus.pps_stb, bus.pps_seq, bus.timer_cnt_out, seq_h, ts_h); end
    bus.align = 1;
    repeat (3) tick();
    bus.align = 0;
    checks++;
    if (bus.pps !== 1'b0 || bus.pps_stb !== 1'b0 || bus.pps_seq !== seq_h)
      begin errors++; $display("FAIL align_idle pps=%b stb=%b seq=%h required 0 0 %h",
        bus.pps, bus.pps_stb, bus.pps_seq, seq_h); end
    bus.en = 1;
    tick();
    checks++;
    if (bus.pps !== 1'b1 || bus.pps_stb !== 1'b1 || bus.pps_seq !== '0 || bus.timer_cnt_out !== ts_before)
      begin errors++; $display("FAIL reenable pps=%b stb=%b seq=%h ts=%h required 1 1 0 %h",
        bus.pps, bus.pps_stb, bus.pps_seq, bus.timer_cnt_out, ts_before); end
  endtask

  task automatic test_rst_mid();
    bus.period = 32'd8; bus.width = 32'd4;
    repeat (2) tick();  // phase 2 of a pulse, pps high
    checks++;
    if (bus.pps !== 1'b1) begin errors++; $display("FAIL rst_mid_pre pps=%b required 1", bus.pps); end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (bus.pps !== 1'b0 || bus.pps_stb !== 1'b0 || bus.pps_seq !== '0 ||
        bus.timer_cnt_out !== '0 || bus.dbg_state !== 1'b0)
      begin errors++; $display("FAIL rst_mid pps=%b stb=%b seq=%h ts=%h required all zero",
        bus.pps, bus.pps_stb, bus.pps_seq, bus.timer_cnt_out); end
    tick();  // en still high: immediate restart
    checks++;
    if (bus.pps !== 1'b1 || bus.pps_stb !== 1'b1 || bus.pps_seq !== '0)
      begin errors++; $display("FAIL rst_restart pps=%b stb=%b seq=%h required 1 1 0",
        bus.pps, bus.pps_stb, bus.pps_seq); end
  endtask

  task automatic test_seq_wrap();
    logic [CW-1:0] want [2];
    int n;
    bit got;
    want[0] = 32'hFFFF_FFFF;
    want[1] = 32'h0000_0000;
    bus.period = 32'd3; bus.width = 32'd1;
    force dut.seq_q = 32'hFFFF_FFFE;
    m_seq = 32'hFFFF_FFFE;
    #1;
    release dut.seq_q;
    for (int k = 0; k < 2; k++) begin
      n = 0; got = 0;
      while (!got && n < 20) begin tick(); n++; if (bus.pps_stb === 1'b1) got = 1; end
      checks++;
      if (!got || bus.pps_seq !== want[k])
        begin errors++; $display("FAIL seq_wrap k=%0d seq=%h required %h", k, bus.pps_seq, want[k]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      bus.en    = ($urandom_range(0, 24) != 0);
      bus.align = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 9) == 0) begin
        bus.period = CW'($urandom_range(0, 12));
        bus.width  = CW'($urandom_range(0, 14));
      end
      tick();
      checks++;
      if (bus.pps !== m_pps || bus.pps_stb !== m_stb || bus.pps_seq !== m_seq ||
          bus.dbg_state !== m_run || (m_stb && bus.timer_cnt_out !== m_ts))
        begin errors++; $display("FAIL random i=%0d pps=%b stb=%b seq=%h st=%b ts=%h required %b %b %h %b %h",
          i, bus.pps, bus.pps_stb, bus.pps_seq, bus.dbg_state, bus.timer_cnt_out,
          m_pps, m_stb, m_seq, m_run, m_ts); end
    end
    rst = 0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1;
    bus.en = 0;
    bus.align = 0;
    bus.period = 32'd10;
    bus.width = 32'd3;
    bus.timer_cnt_in = TW'({$urandom, $urandom, $urandom});
    test_reset();
    test_enable();
    test_reprogram();
    test_clamp();
    test_align();
    test_disable();
    test_rst_mid();
    test_seq_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
